// File: rtl/maze_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maze_move_ctrl
// Brief    : Moore controller for the maze game datapath. Samples the decoded
//            arrow key, looks up the destination cell, then erases, steps and
//            redraws the player. Handles ice sliding, lava freeze/respawn and
//            wall blocking, and counts completed steps.
// Revision : 1.0 - initial release
// ============================================================================
module maze_move_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] move,
  input  logic       obs_wall,
  input  logic       obs_lava,
  input  logic       obs_ice,
  input  logic       timer_done,
  input  logic       unfrozen,
  output logic       en_xpos,
  output logic [1:0] s_xpos,
  output logic       en_ypos,
  output logic [1:0] s_ypos,
  output logic       en_key,
  output logic       s_key,
  output logic       en_obs,
  output logic [2:0] s_obs,
  output logic       en_timer,
  output logic       s_timer,
  output logic [1:0] s_color,
  output logic       plot,
  output logic       busy,
  output logic       frozen,
  output logic [7:0] move_count
);

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_DRAW_INIT  = 4'd1,
    S_IDLE       = 4'd2,
    S_LOOK       = 4'd3,
    S_MEM_WAIT   = 4'd4,
    S_CHECK      = 4'd5,
    S_ERASE      = 4'd6,
    S_STEP       = 4'd7,
    S_DRAW       = 4'd8,
    S_SLIDE_WAIT = 4'd9,
    S_FROZEN     = 4'd10,
    S_RESPAWN    = 4'd11
  } state_t;

  // Destination cell classes remembered between CHECK and DRAW
  localparam logic [1:0] c_DEST_NORMAL = 2'd0;
  localparam logic [1:0] c_DEST_LAVA   = 2'd1;
  localparam logic [1:0] c_DEST_ICE    = 2'd2;

  // Last wait-counter value before the obstacle data is valid
  localparam logic [2:0] c_WAIT_LAST = 3'(MEM_LAT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_dir;
  logic [1:0] r_dest;
  logic [2:0] r_wait;
  logic [7:0] r_move_count;

  // State register; reset forces INIT from any state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Direction, destination class, memory wait counter and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir        <= 3'd0;
      r_dest       <= c_DEST_NORMAL;
      r_wait       <= 3'd0;
      r_move_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (move != 3'd0) begin
            r_dir <= move;
          end
        end
        S_LOOK: begin
          r_wait <= 3'd0;
        end
        S_MEM_WAIT: begin
          r_wait <= r_wait + 3'd1;
        end
        S_CHECK: begin
          // Wall leaves the class untouched; it is never drawn
          if (!obs_wall) begin
            if (obs_lava) begin
              r_dest <= c_DEST_LAVA;
            end else if (obs_ice) begin
              r_dest <= c_DEST_ICE;
            end else begin
              r_dest <= c_DEST_NORMAL;
            end
          end
        end
        S_STEP: begin
          if (r_move_count != 8'hFF) begin
            r_move_count <= r_move_count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and Moore decode of all datapath controls
  always_comb begin
    w_state_nxt = r_state;
    en_xpos     = 1'b0;
    s_xpos      = 2'd0;
    en_ypos     = 1'b0;
    s_ypos      = 2'd0;
    en_key      = 1'b0;
    s_key       = 1'b0;
    en_obs      = 1'b0;
    s_obs       = 3'd0;
    en_timer    = 1'b0;
    s_timer     = 1'b0;
    s_color     = 2'd0;
    plot        = 1'b0;
    busy        = 1'b1;
    frozen      = 1'b0;

    case (r_state)
      S_INIT: begin
        en_xpos     = 1'b1;
        en_ypos     = 1'b1;
        en_timer    = 1'b1;
        en_key      = 1'b1;
        w_state_nxt = S_DRAW_INIT;
      end
      S_DRAW_INIT: begin
        plot        = 1'b1;
        s_color     = 2'd1;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        busy   = 1'b0;
        en_key = 1'b1;
        s_key  = 1'b1;
        if (move != 3'd0) begin
          w_state_nxt = S_LOOK;
        end
      end
      S_LOOK: begin
        en_obs      = 1'b1;
        s_obs       = r_dir;
        en_key      = 1'b1;
        w_state_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (r_wait == c_WAIT_LAST) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_nxt = obs_wall ? S_IDLE : S_ERASE;
      end
      S_ERASE: begin
        plot        = 1'b1;
        w_state_nxt = S_STEP;
      end
      S_STEP: begin
        case (r_dir)
          3'd1: begin en_xpos = 1'b1; s_xpos = 2'd2; end
          3'd2: begin en_xpos = 1'b1; s_xpos = 2'd1; end
          3'd3: begin en_ypos = 1'b1; s_ypos = 2'd2; end
          3'd4: begin en_ypos = 1'b1; s_ypos = 2'd1; end
          default: begin end
        endcase
        w_state_nxt = S_DRAW;
      end
      S_DRAW: begin
        plot     = 1'b1;
        s_color  = (r_dest == c_DEST_LAVA) ? 2'd2 : 2'd1;
        en_timer = 1'b1;
        case (r_dest)
          c_DEST_LAVA: w_state_nxt = S_FROZEN;
          c_DEST_ICE:  w_state_nxt = S_SLIDE_WAIT;
          default:     w_state_nxt = S_IDLE;
        endcase
      end
      S_SLIDE_WAIT: begin
        en_timer = 1'b1;
        s_timer  = 1'b1;
        if (timer_done) begin
          w_state_nxt = S_LOOK;
        end
      end
      S_FROZEN: begin
        frozen   = 1'b1;
        en_timer = 1'b1;
        s_timer  = 1'b1;
        if (unfrozen) begin
          w_state_nxt = S_RESPAWN;
        end
      end
      S_RESPAWN: begin
        plot        = 1'b1;
        w_state_nxt = S_INIT;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign move_count = r_move_count;

endmodule
`default_nettype wire

// File: tb/tb_maze_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_move_ctrl
// Brief    : Self-checking bench for maze_move_ctrl: directed cycle table,
//            randomized play against a game-level reference model, and
//            hand-written reset / saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maze_move_ctrl;
  localparam int L  = 1;      // obstacle memory latency
  localparam int P  = 3;      // slide-step timer period
  localparam int F  = 6;      // freeze timer period
  localparam int NC = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] move;
  logic       obs_wall, obs_lava, obs_ice, timer_done, unfrozen;
  logic       en_xpos, en_ypos, en_key, s_key, en_obs, en_timer, s_timer;
  logic       plot, busy, frozen;
  logic [1:0] s_xpos, s_ypos, s_color;
  logic [2:0] s_obs;
  logic [7:0] move_count;

  maze_move_ctrl #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .move(move),
    .obs_wall(obs_wall), .obs_lava(obs_lava), .obs_ice(obs_ice),
    .timer_done(timer_done), .unfrozen(unfrozen),
    .en_xpos(en_xpos), .s_xpos(s_xpos), .en_ypos(en_ypos), .s_ypos(s_ypos),
    .en_key(en_key), .s_key(s_key), .en_obs(en_obs), .s_obs(s_obs),
    .en_timer(en_timer), .s_timer(s_timer), .s_color(s_color),
    .plot(plot), .busy(busy), .frozen(frozen), .move_count(move_count)
  );

  // ---------------- environment: datapath, obstacle memory, timer ----------
  logic       tab_mode = 1'b1;
  logic [2:0] t_wli = 3'd0;   // {wall, lava, ice} from the table
  logic       t_td = 1'b0, t_uf = 1'b0;
  logic [7:0] x = 8'd0, y = 8'd0, ox = 8'd0, oy = 8'd0, tcnt = 8'd0;
  logic [1:0] mp [16][16];    // 0 normal, 1 wall, 2 lava, 3 ice
  logic [2:0] pipe [L];

  function automatic logic [7:0] dxf(input logic [2:0] d);
    if (d == 3'd1) return 8'hFF;
    if (d == 3'd2) return 8'h01;
    return 8'h00;
  endfunction
  function automatic logic [7:0] dyf(input logic [2:0] d);
    if (d == 3'd3) return 8'hFF;
    if (d == 3'd4) return 8'h01;
    return 8'h00;
  endfunction
  function automatic logic [2:0] cell_flags(input logic [7:0] cx, input logic [7:0] cy);
    logic [1:0] t;
    t = mp[cx[3:0]][cy[3:0]];
    return {t == 2'd1, t == 2'd2, t == 2'd3};
  endfunction

  always @(posedge clk) begin
    if (en_xpos) x <= (s_xpos == 2'd0) ? 8'h86 : (s_xpos == 2'd1) ? x + 8'd1 : (s_xpos == 2'd2) ? x - 8'd1 : x;
    if (en_ypos) y <= (s_ypos == 2'd0) ? 8'h77 : (s_ypos == 2'd1) ? y + 8'd1 : (s_ypos == 2'd2) ? y - 8'd1 : y;
    if (en_obs) begin
      ox <= x + dxf(s_obs);
      oy <= y + dyf(s_obs);
    end
    pipe[0] <= cell_flags(ox, oy);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    if (en_timer) tcnt <= s_timer ? ((tcnt == 8'hFF) ? tcnt : tcnt + 8'd1) : 8'd0;
  end

  assign obs_wall   = tab_mode ? t_wli[2] : pipe[L-1][2];
  assign obs_lava   = tab_mode ? t_wli[1] : pipe[L-1][1];
  assign obs_ice    = tab_mode ? t_wli[0] : pipe[L-1][0];
  assign timer_done = tab_mode ? t_td : (tcnt >= 8'(P));
  assign unfrozen   = tab_mode ? t_uf : (tcnt >= 8'(F));

  // ---------------- checking helpers --------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  logic [15:0] act_pk;
  assign act_pk = {plot, s_color, busy, frozen, en_xpos, s_xpos, en_ypos, s_ypos,
                   en_key, s_key, en_obs, en_timer, s_timer};

  function automatic logic [15:0] pk(input int p, c, b, f, ex, sx, ey, sy, ek, sk, eo, et, st);
    return {p[0], c[1:0], b[0], f[0], ex[0], sx[1:0], ey[0], sy[1:0], ek[0], sk[0], eo[0], et[0], st[0]};
  endfunction

  logic [15:0] e_init, e_drawi, e_idle, e_look, e_busy, e_erase, e_stepr, e_stepd;
  logic [15:0] e_drawg, e_drawb, e_slide, e_froz, e_resp;

  typedef struct {
    logic        rst;
    logic [2:0]  mv;
    logic [2:0]  wli;
    logic        td;
    logic        uf;
    logic        ck;
    logic [15:0] ex;
    logic [2:0]  sobs;
    int          mc;
  } vec_t;
  vec_t tab[$];

  function automatic vec_t V(input int r, mv, wli, td, uf, ck, input logic [15:0] ex, input int so, mc);
    vec_t v;
    v.rst = r[0]; v.mv = mv[2:0]; v.wli = wli[2:0]; v.td = td[0]; v.uf = uf[0];
    v.ck = ck[0]; v.ex = ex; v.sobs = so[2:0]; v.mc = mc;
    return v;
  endfunction

  // ---------------- game-level reference model ---------------------------
  logic       e_plot [NC];
  logic [1:0] e_col  [NC];
  logic       e_bsy  [NC];
  logic       e_frz  [NC];
  logic [7:0] e_px   [NC];
  logic [7:0] e_py   [NC];
  logic [7:0] e_cnt  [NC];
  logic [7:0] px, py, mc;
  int         free_at;

  task automatic sched(input int k, input logic p, input logic [1:0] c, input logic f);
    if (k < NC) begin
      e_plot[k] = p; e_col[k] = c; e_bsy[k] = 1'b1; e_frz[k] = f;
      e_px[k] = px; e_py[k] = py; e_cnt[k] = mc;
    end
  endtask

  // Resolve a whole accepted move (including any slide chain) into a timeline
  task automatic resolve(input int c, input logic [2:0] d);
    int t;
    logic [7:0] nx, ny;
    logic [1:0] ty;
    t = c;
    for (int it = 0; it < 64; it++) begin
      nx = px + dxf(d);
      ny = py + dyf(d);
      ty = mp[nx[3:0]][ny[3:0]];
      for (int k = t + 1; k <= t + 2 + L; k++) sched(k, 1'b0, 2'd0, 1'b0);
      if (ty == 2'd1) begin
        free_at = t + 3 + L;
        return;
      end
      sched(t + 3 + L, 1'b1, 2'd0, 1'b0);
      sched(t + 4 + L, 1'b0, 2'd0, 1'b0);
      px = nx; py = ny;
      if (mc != 8'hFF) mc = mc + 8'd1;
      if (ty == 2'd2) begin
        sched(t + 5 + L, 1'b1, 2'd2, 1'b0);
        for (int k = t + 6 + L; k <= t + 6 + L + F; k++) sched(k, 1'b0, 2'd0, 1'b1);
        sched(t + 7 + L + F, 1'b1, 2'd0, 1'b0);
        sched(t + 8 + L + F, 1'b0, 2'd0, 1'b0);
        px = 8'h86; py = 8'h77;
        sched(t + 9 + L + F, 1'b1, 2'd1, 1'b0);
        free_at = t + 10 + L + F;
        return;
      end
      sched(t + 5 + L, 1'b1, 2'd1, 1'b0);
      if (ty == 2'd0) begin
        free_at = t + 6 + L;
        return;
      end
      for (int k = t + 6 + L; k <= t + 6 + L + P; k++) sched(k, 1'b0, 2'd0, 1'b0);
      t = t + 6 + L + P;
    end
    free_at = t + 1;
  endtask

  // Map: index-0 row and column are walls so every slide terminates
  task automatic fill_map(input bit rnd);
    int r;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        r = $urandom_range(99);
        if (i == 0 || j == 0) mp[i][j] = 2'd1;
        else if (!rnd || (i == 6 && j == 7)) mp[i][j] = 2'd0;
        else mp[i][j] = (r < 55) ? 2'd0 : (r < 70) ? 2'd1 : (r < 80) ? 2'd2 : 2'd3;
      end
  endtask

  task automatic start_run();
    tab_mode = 1'b0;
    reset = 1'b1; move = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_model(input int ncyc, input int keypct);
    logic [2:0] mv;
    start_run();
    px = 8'h86; py = 8'h77; mc = 8'd0;
    sched(0, 1'b0, 2'd0, 1'b0);
    sched(1, 1'b1, 2'd1, 1'b0);
    free_at = 2;
    for (int n = 0; n < ncyc; n++) begin
      mv = ($urandom_range(99) < keypct) ? 3'($urandom_range(4, 1)) : 3'd0;
      move = mv;
      if (n >= free_at) begin
        e_plot[n] = 1'b0; e_bsy[n] = 1'b0; e_frz[n] = 1'b0; e_cnt[n] = mc;
        e_col[n] = 2'd0; e_px[n] = px; e_py[n] = py;
        if (mv != 3'd0) resolve(n, mv);
      end
      @(negedge clk);
      chk("plot", plot, e_plot[n]);
      chk("busy", busy, e_bsy[n]);
      chk("frozen", frozen, e_frz[n]);
      chk("move_count", move_count, e_cnt[n]);
      if (plot && e_plot[n]) begin
        chk("color", s_color, e_col[n]);
        chk("pix_x", x, e_px[n]);
        chk("pix_y", y, e_py[n]);
      end
      @(posedge clk);
      #1;
    end
    move = 3'd0;
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    e_init  = pk(0,0,1,0, 1,0, 1,0, 1,0, 0, 1,0);
    e_drawi = pk(1,1,1,0, 0,0, 0,0, 0,0, 0, 0,0);
    e_idle  = pk(0,0,0,0, 0,0, 0,0, 1,1, 0, 0,0);
    e_look  = pk(0,0,1,0, 0,0, 0,0, 1,0, 1, 0,0);
    e_busy  = pk(0,0,1,0, 0,0, 0,0, 0,0, 0, 0,0);
    e_erase = pk(1,0,1,0, 0,0, 0,0, 0,0, 0, 0,0);
    e_stepr = pk(0,0,1,0, 1,1, 0,0, 0,0, 0, 0,0);
    e_stepd = pk(0,0,1,0, 0,0, 1,1, 0,0, 0, 0,0);
    e_drawg = pk(1,1,1,0, 0,0, 0,0, 0,0, 0, 1,0);
    e_drawb = pk(1,2,1,0, 0,0, 0,0, 0,0, 0, 1,0);
    e_slide = pk(0,0,1,0, 0,0, 0,0, 0,0, 0, 1,1);
    e_froz  = pk(0,0,1,1, 0,0, 0,0, 0,0, 0, 1,1);
    e_resp  = pk(1,0,1,0, 0,0, 0,0, 0,0, 0, 0,0);

    //            rst mv wli td uf ck expected  sobs mc
    tab.push_back(V(1, 0, 0, 0, 0, 0, e_init,  0, -1));
    tab.push_back(V(1, 0, 0, 0, 0, 1, e_init,  0,  0));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_init,  0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_drawi, 0, -1));
    tab.push_back(V(0, 2, 0, 0, 0, 1, e_idle,  0,  0));   // right
    tab.push_back(V(0, 3, 0, 0, 0, 1, e_look,  2, -1));   // key while busy
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_busy,  0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_busy,  0, -1));   // CHECK normal
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_erase, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_stepr, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_drawg, 0, -1));   // 6 cycles after key
    tab.push_back(V(0, 1, 0, 0, 0, 1, e_idle,  0,  1));   // left
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_look,  1, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_busy,  0, -1));
    tab.push_back(V(0, 0, 7, 0, 0, 1, e_busy,  0, -1));   // wall wins
    tab.push_back(V(0, 4, 0, 0, 0, 1, e_idle,  0,  1));   // down
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_look,  4, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_busy,  0, -1));
    tab.push_back(V(0, 0, 1, 0, 0, 1, e_busy,  0, -1));   // ice
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_erase, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_stepd, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_drawg, 0, -1));
    tab.push_back(V(0, 2, 0, 0, 0, 1, e_slide, 0, -1));   // key ignored
    tab.push_back(V(0, 0, 0, 1, 0, 1, e_slide, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_look,  4, -1));   // same dir
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_busy,  0, -1));
    tab.push_back(V(0, 0, 3, 0, 0, 1, e_busy,  0, -1));   // lava over ice
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_erase, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_stepd, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_drawb, 0,  3));
    tab.push_back(V(0, 0, 0, 1, 0, 1, e_froz,  0, -1));   // timer_done ignored
    tab.push_back(V(0, 0, 0, 1, 1, 1, e_froz,  0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_resp,  0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_init,  0,  3));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_drawi, 0, -1));
    tab.push_back(V(0, 3, 0, 0, 0, 1, e_idle,  0,  3));   // up
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_look,  3, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_busy,  0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_busy,  0, -1));
    tab.push_back(V(1, 0, 0, 0, 0, 1, e_erase, 0, -1));   // reset in ERASE
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_init,  0,  0));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_drawi, 0, -1));
    tab.push_back(V(0, 0, 0, 0, 0, 1, e_idle,  0,  0));

    tab_mode = 1'b1;
    for (int i = 0; i < tab.size(); i++) begin
      reset = tab[i].rst; move = tab[i].mv; t_wli = tab[i].wli;
      t_td = tab[i].td; t_uf = tab[i].uf;
      @(negedge clk);
      if (tab[i].ck) begin
        chk($sformatf("tab%0d_outs", i), act_pk, tab[i].ex);
        chk($sformatf("tab%0d_s_obs", i), s_obs, tab[i].sobs);
        if (tab[i].mc >= 0) chk($sformatf("tab%0d_move_count", i), move_count, tab[i].mc);
      end
      @(posedge clk);
      #1;
    end

    // Open field: many steps, move_count must saturate
    fill_map(1'b0);
    run_model(3000, 60);
    chk("saturated_count", move_count, 32'd255);

    // Random maze with walls, lava and ice
    fill_map(1'b1);
    run_model(4000, 30);

    // Reset in the middle of an ice slide
    fill_map(1'b0);
    mp[7][7] = 2'd3;
    start_run();
    repeat (2) begin @(posedge clk); #1; end
    move = 3'd2;
    @(posedge clk); #1;
    move = 3'd0;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("slide_outs", act_pk, e_slide);
    chk("slide_count", move_count, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_slide_outs", act_pk, e_init);
    chk("rst_slide_count", move_count, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_slide_plot", plot, 32'd1);
    chk("rst_slide_x", x, 32'h86);
    chk("rst_slide_y", y, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
